// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, queue entry type and PC helper for the fetch stage
package fetch_pkg;
  localparam int XLEN    = 64;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0]    PC_STEP   = 64'd4;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } ifq_entry_t;

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction
endpackage

// File: rtl/instr_fetch_queue_if.sv
// rtl/instr_fetch_queue_if.sv - redirect, imem request/response and decode-side handshake bundle
interface instr_fetch_queue_if #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                          redirect_valid;
  logic [XLEN-1:0]               redirect_pc;
  logic                          imem_req_valid;
  logic                          imem_req_ready;
  logic [XLEN-1:0]               imem_req_addr;
  logic                          imem_rsp_valid;
  logic [fetch_pkg::INSTR_W-1:0] imem_rsp_data;
  logic                          ifq_valid;
  logic                          ifq_ready;
  logic [XLEN-1:0]               ifq_pc;
  logic [fetch_pkg::INSTR_W-1:0] ifq_instr;
  logic [CNT_W-1:0]              ifq_count;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output ifq_valid, ifq_pc, ifq_instr, ifq_count,
    input  ifq_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  ifq_valid, ifq_pc, ifq_instr, ifq_count,
    output ifq_ready
  );
endinterface

// File: rtl/ifq_fifo.sv
// rtl/ifq_fifo.sv - in-order circular buffer of {pc, instr}; wrap-bit pointers give full/empty
module ifq_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int PW   = AW + 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       wr_en,
  input  ifq_entry_t wr_data,
  input  logic       rd_en,
  output ifq_entry_t rd_data,
  output logic [PW-1:0] count,
  output logic       empty
);
  ifq_entry_t    mem_q [DEPTH];
  ifq_entry_t    mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;

  assign count   = tail_q - head_q;
  assign empty   = (count == '0);
  assign rd_data = mem_q[head_q[AW-1:0]];

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (wr_en) begin
        mem_d[tail_q[AW-1:0]] = wr_data;
        tail_d = tail_q + PW'(1);
      end
      if (rd_en) begin
        head_d = head_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q  <= '{default: '0};
      head_q <= '0;
      tail_q <= '0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end
endmodule

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - fetch PC, imem issue/response tracking and decode queue
// FETCH_BYPASS_EN: forward a live response straight to decode when the queue is empty.
module instr_fetch_queue #(
  parameter int              XLEN            = 64,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_queue_if.master bus
);
  import fetch_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int SUM_W = CNT_W + OUT_W + 1;

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic [OUT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [OUT_W-1:0] live_outstanding;
  logic [SUM_W-1:0] occ_sum;
  logic             req_valid;
  logic             req_fire;
  logic             rsp_stale;
  logic             rsp_live;
  logic             fifo_wr;
  logic             fifo_rd;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  ifq_entry_t       rsp_entry;
  ifq_entry_t       head_entry;

  // Stale requests will never land in the queue, so only live ones reserve a slot.
  assign live_outstanding = outstanding_q - drop_cnt_q;
  assign occ_sum   = SUM_W'(fifo_count) + SUM_W'(live_outstanding);
  assign req_valid = !reset && !bus.redirect_valid
                     && (outstanding_q < OUT_W'(MAX_OUTSTANDING))
                     && (occ_sum < SUM_W'(DEPTH));
  assign req_fire  = req_valid && bus.imem_req_ready;
  assign rsp_stale = (drop_cnt_q != '0);
  assign rsp_live  = !reset && bus.imem_rsp_valid && !rsp_stale && !bus.redirect_valid;
  assign rsp_entry = '{pc: rsp_pc_q, instr: bus.imem_rsp_data};
  assign fifo_rd   = !fifo_empty && bus.ifq_ready && !bus.redirect_valid;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.ifq_count      = fifo_count;

`ifdef FETCH_BYPASS_EN
  logic byp_take;
  assign byp_take      = fifo_empty && rsp_live;
  assign fifo_wr       = rsp_live && !(byp_take && bus.ifq_ready);
  assign bus.ifq_valid = !fifo_empty || byp_take;
  assign bus.ifq_pc    = byp_take ? rsp_entry.pc    : head_entry.pc;
  assign bus.ifq_instr = byp_take ? rsp_entry.instr : head_entry.instr;
`else
  assign fifo_wr       = rsp_live;
  assign bus.ifq_valid = !fifo_empty;
  assign bus.ifq_pc    = head_entry.pc;
  assign bus.ifq_instr = head_entry.instr;
`endif

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + OUT_W'(req_fire) - OUT_W'(bus.imem_rsp_valid);
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc;
      rsp_pc_d   = bus.redirect_pc;
      drop_cnt_d = outstanding_q - OUT_W'(bus.imem_rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc_d = next_pc(fetch_pc_q);
      end
      if (bus.imem_rsp_valid) begin
        if (rsp_stale) begin
          drop_cnt_d = drop_cnt_q - OUT_W'(1);
        end else begin
          rsp_pc_d = next_pc(rsp_pc_q);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (bus.redirect_valid),
    .wr_en   (fifo_wr),
    .wr_data (rsp_entry),
    .rd_en   (fifo_rd),
    .rd_data (head_entry),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );
endmodule
